exc_ctrl: RTL

- Exception/interrupt sequencer sitting between the writeback stage and the CSR register file.
- Each cycle it prioritises exception flags from the retiring WB instruction, together with pending interrupts, and drives the CSR file's commit inputs: wb_ex, ecode/esubcode, ERA pc, bad vaddr and ertn_flush.
- It then holds a pipeline-wide flush and a fetch redirect until IF accepts the new PC.

---
 rtl/exc_ctrl_pkg.sv | 30 +++
 rtl/exc_prio_enc.sv | 45 ++++
 rtl/exc_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: ecode/esubcode values,
// FSM state encoding and the bad-vaddr source select.
// Imported by exc_prio_enc and exc_ctrl.
package exc_ctrl_pkg;

  // Exception codes driven into ESTAT.Ecode on commit.
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Every exception this block raises uses esubcode 0 (ADEF included).
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_e;

  // Which value goes to BADV on commit.
  typedef enum logic [1:0] {
    VA_NONE = 2'd0,
    VA_PC   = 2'd1,
    VA_BADV = 2'd2
  } vaddr_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Purely combinational exception priority encoder.
// Ports: int_i + WB exception flags in; any_ex_o, ecode_o, esubcode_o and
//        vaddr_sel_o (source of the bad virtual address) out.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_i,
  input  logic       ex_adef_i,
  input  logic       ex_ine_i,
  input  logic       ex_sys_i,
  input  logic       ex_brk_i,
  input  logic       ex_ale_i,
  output logic       any_ex_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o,
  output vaddr_sel_e vaddr_sel_o
);

  // Highest priority first; lower-priority flags are simply dropped.
  always_comb begin
    any_ex_o    = 1'b1;
    ecode_o     = 6'h00;
    esubcode_o  = ESUBCODE_NONE;
    vaddr_sel_o = VA_NONE;
    if (int_i) begin
      ecode_o = ECODE_INT;
    end else if (ex_adef_i) begin
      ecode_o     = ECODE_ADEF;
      esubcode_o  = ESUBCODE_ADEF;
      vaddr_sel_o = VA_PC;
    end else if (ex_ine_i) begin
      ecode_o = ECODE_INE;
    end else if (ex_sys_i) begin
      ecode_o = ECODE_SYS;
    end else if (ex_brk_i) begin
      ecode_o = ECODE_BRK;
    end else if (ex_ale_i) begin
      ecode_o     = ECODE_ALE;
      vaddr_sel_o = VA_BADV;
    end else begin
      any_ex_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between WB and the CSR file. Commits the
// winning exception or ertn in the WB cycle, then holds flush + redirect
// until IF accepts the new PC.
// Ports: clk/resetn; WB instruction info and exception flags; CSR state
//        (CRMD.IE, ESTAT.IS, ECFG.LIE, EENTRY, ERA); CSR commit outputs
//        (wb_ex, ecode/esubcode, ERA pc, bad vaddr, ertn_flush); pipeline
//        flush; redirect valid/pc/ready handshake; ctrl_busy.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int NUM_INT = 13,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ws_valid,
  input  logic [ADDR_W-1:0] ws_pc,
  input  logic              ws_ex_adef,
  input  logic              ws_ex_ine,
  input  logic              ws_ex_sys,
  input  logic              ws_ex_brk,
  input  logic              ws_ex_ale,
  input  logic [ADDR_W-1:0] ws_badv,
  input  logic              ws_ertn,
  input  logic              csr_crmd_ie,
  input  logic [NUM_INT-1:0] csr_estat_is,
  input  logic [NUM_INT-1:0] csr_ecfg_lie,
  input  logic [ADDR_W-1:0] csr_ex_entry,
  input  logic [ADDR_W-1:0] csr_era,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [ADDR_W-1:0] wb_csr_pc,
  output logic [ADDR_W-1:0] wb_vaddr,
  output logic              ertn_flush,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              ctrl_busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                int_q, int_d;

  logic                any_ex;
  logic [5:0]          enc_ecode;
  logic [8:0]          enc_esubcode;
  vaddr_sel_e          enc_vaddr_sel;

  logic                evt_en;
  logic                ex_take;
  logic                ertn_take;

  // Interrupt request is registered, so a CSR write that raises it is seen
  // by the next WB instruction, and it stays pending across bubbles.
  assign int_d = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));

  exc_prio_enc u_prio (
    .int_i       (int_q),
    .ex_adef_i   (ws_ex_adef),
    .ex_ine_i    (ws_ex_ine),
    .ex_sys_i    (ws_ex_sys),
    .ex_brk_i    (ws_ex_brk),
    .ex_ale_i    (ws_ex_ale),
    .any_ex_o    (any_ex),
    .ecode_o     (enc_ecode),
    .esubcode_o  (enc_esubcode),
    .vaddr_sel_o (enc_vaddr_sel)
  );

  // WB is only examined while idle; during REDIR the instruction in WB is
  // already being killed by flush.
  assign evt_en    = ws_valid & (state_q == ST_IDLE);
  assign ex_take   = evt_en & any_ex;
  assign ertn_take = evt_en & ws_ertn & ~any_ex;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      int_q   <= int_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_take) begin
          tgt_d   = csr_ex_entry;
          state_d = ST_REDIR;
        end else if (ertn_take) begin
          tgt_d   = csr_era;
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Everything is forced low while reset is asserted so that
  // no commit strobe escapes in the reset cycle itself.
  always_comb begin
    wb_ex          = 1'b0;
    wb_ecode       = 6'h00;
    wb_esubcode    = 9'h000;
    wb_csr_pc      = '0;
    wb_vaddr       = '0;
    ertn_flush     = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ctrl_busy      = 1'b0;
    if (resetn) begin
      case (state_q)
        ST_IDLE: begin
          if (ex_take) begin
            wb_ex       = 1'b1;
            wb_ecode    = enc_ecode;
            wb_esubcode = enc_esubcode;
            wb_csr_pc   = ws_pc;
            case (enc_vaddr_sel)
              VA_PC:   wb_vaddr = ws_pc;
              VA_BADV: wb_vaddr = ws_badv;
              default: wb_vaddr = '0;
            endcase
          end
          ertn_flush = ertn_take;
          flush      = ex_take | ertn_take;
        end
        ST_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = tgt_q;
          flush          = 1'b1;
          ctrl_busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
